// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, with registered borrow.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             overflow,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          br;
    logic          accept;
    logic          last;
    logic          d;
    logic          br_next;

    assign accept  = (state == RUN) && bit_valid;
    assign last    = accept && (cnt == CW'(WIDTH - 1));
    assign d       = a_bit ^ b_bit ^ br;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Counter stops at WIDTH-1 on the final pair so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            br         <= 1'b0;
            diff_bit   <= 1'b0;
            diff_valid <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= 1'b0;
`endif
        end else begin
            diff_valid <= accept;
            if (state == IDLE && start) begin
                cnt        <= '0;
                br         <= 1'b0;
                result     <= '0;
                borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                overflow   <= 1'b0;
`endif
            end
            if (accept) begin
                diff_bit <= d;
                result   <= {d, result[WIDTH-1:1]};
                br       <= br_next;
                if (!last) cnt <= cnt + 1'b1;
            end
            if (last) begin
                borrow_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                overflow   <= (a_bit ^ b_bit) & (a_bit ^ d);
`endif
            end
        end
    end

endmodule
